pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline. It drives the Stall and flush inputs of the PC, IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers. It resolves three hazard classes: load-use hazards, taken branches resolved in EX, and multi-cycle data-memory accesses in MEM (fixed-latency wait FSM). It also keeps saturating per-cause stall counters for performance comparison runs.

Parameters:
MEM_LAT, 2, extra wait cycles per data-memory access in MEM (0 = single-cycle memory, FSM never leaves RUN)
CNT_W, 16, width of each performance counter

Ports:
clk  input  1  pipeline clock
rst  input  1  asynchronous reset, active-low (0 = reset)
ID_Rs  input  5  source register Rs of the instruction in ID
ID_Rt  input  5  source register Rt of the instruction in ID
ID_UseRt  input  1  ID instruction reads Rt
EX_Rdst  input  5  destination register of the instruction in EX
EX_MemR  input  1  EX instruction is a load
EX_BrTaken  input  1  branch/jump in EX resolved taken
MEM_MemR  input  1  MEM instruction reads data memory
MEM_MemW  input  1  MEM instruction writes data memory
PC_Stall  output  1  hold PC
IF_ID_Stall  output  1  hold IF_ID
IF_ID_Flush  output  1  clear IF_ID
ID_EX_Stall  output  1  hold ID_EX
ID_EX_Flush  output  1  clear ID_EX (bubble)
EX_MEM_Stall  output  1  hold EX_MEM
MEM_WB_Flush  output  1  clear MEM_WB (bubble into WB)
Mem_Busy  output  1  FSM in MEM_WAIT
Cnt_LoadUse  output  CNT_W  load-use stall cycles
Cnt_Branch  output  CNT_W  taken-branch flush events
Cnt_MemWait  output  CNT_W  memory wait cycles

Behaviour:
- State: FSM {RUN, MEM_WAIT}, wait counter wcnt (width clog2(MEM_LAT+1), min 1), three perf counters. All registered on posedge clk.
- Reset: rst=0 asynchronously forces the FSM to RUN, and wcnt and all perf counters to 0. While rst=0, all stall/flush outputs and Mem_Busy are forced to 0. Reset applied during MEM_WAIT abandons the access.
- Stall/flush outputs are combinational (Mealy) from state and current inputs, so the same-cycle response is 0-latency.
- Detect signals:
  - mem_acc = MEM_MemR | MEM_MemW.
  - lu = EX_MemR & (EX_Rdst != 0) & ((EX_Rdst == ID_Rs) | (ID_UseRt & (EX_Rdst == ID_Rt))).
- mem_stall is 1 in either of these cases:
  - state=RUN & mem_acc & MEM_LAT>0
  - state=MEM_WAIT & wcnt!=0
- Priority: mem_stall > EX_BrTaken > lu. Lower causes are masked while a higher one is active; they re-evaluate once it clears because the frozen stages still hold them.
- mem_stall active:
  - Asserted: PC_Stall, IF_ID_Stall, ID_EX_Stall, EX_MEM_Stall, MEM_WB_Flush.
  - All other outputs are 0.
- EX_BrTaken (no mem_stall): IF_ID_Flush=1, ID_EX_Flush=1; all stalls 0.
- lu (no mem_stall, no branch): PC_Stall=1, IF_ID_Stall=1, ID_EX_Flush=1. Exactly one bubble per hazard, because the load advances to MEM next cycle.
- None active: all outputs 0.
- FSM transitions:
  - RUN -> MEM_WAIT when mem_acc & MEM_LAT>0; wcnt <= MEM_LAT-1.
  - MEM_WAIT, wcnt!=0: wcnt <= wcnt-1.
  - MEM_WAIT, wcnt==0: outputs released this cycle, the access instruction advances at the clock edge, and the FSM goes to RUN.
  - Net effect: each access holds MEM for exactly MEM_LAT stall cycles (MEM_LAT+1 total cycles in MEM).
  - Back-to-back accesses: the next instruction entering MEM in RUN retriggers immediately. There is no idle cycle required between accesses.
- Mem_Busy = (state==MEM_WAIT).
- Perf counters:
  - Cnt_LoadUse: +1 per cycle the lu response is driven.
  - Cnt_Branch: +1 per cycle the branch response is driven.
  - Cnt_MemWait: +1 per cycle mem_stall=1.
  - All three saturate at 2^CNT_W-1 and never wrap.
- Register $0 never causes a load-use hazard.

Test Plan:
- Reset mid-wait: MEM_LAT=2, MEM_MemR=1 for 1 cycle, then rst=0 asynchronously during MEM_WAIT -> outputs drop to 0 immediately, Mem_Busy=0, counters=0. After rst=1 with mem_acc=0, the block stays in RUN.
- Load-use: EX_MemR=1, EX_Rdst=5, ID_Rs=5 -> PC_Stall=IF_ID_Stall=ID_EX_Flush=1 for 1 cycle, Cnt_LoadUse=1. Same stimulus with EX_Rdst=0 -> all 0. With ID_Rt=5 and ID_UseRt=0 -> all 0.
- Taken branch plus load-use in the same cycle: EX_BrTaken=1 and lu true -> IF_ID_Flush=ID_EX_Flush=1, PC_Stall=0, Cnt_Branch=1, Cnt_LoadUse=0.
- Memory wait: MEM_LAT=2, MEM_MemW held 1 -> stall set plus MEM_WB_Flush for exactly 2 cycles, released on the 3rd. Cnt_MemWait=2. Back-to-back second access restalls 2 cycles with no gap.
- Masking: EX_BrTaken=1 and lu held during MEM_WAIT -> only the mem stall set is asserted. The branch flush appears in the first cycle after release.
- Saturation: CNT_W=4, 20 load-use cycles -> Cnt_LoadUse=15. MEM_LAT=0 with mem_acc=1 -> no stalls, Mem_Busy stays 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, taken-branch
// flushes and a fixed-latency data-memory wait FSM, plus saturating stall counters.
module pipe_hazard_ctrl #(
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ID_Rs,
    input  logic [4:0]       ID_Rt,
    input  logic             ID_UseRt,
    input  logic [4:0]       EX_Rdst,
    input  logic             EX_MemR,
    input  logic             EX_BrTaken,
    input  logic             MEM_MemR,
    input  logic             MEM_MemW,
    output logic             PC_Stall,
    output logic             IF_ID_Stall,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Stall,
    output logic             ID_EX_Flush,
    output logic             EX_MEM_Stall,
    output logic             MEM_WB_Flush,
    output logic             Mem_Busy,
    output logic [CNT_W-1:0] Cnt_LoadUse,
    output logic [CNT_W-1:0] Cnt_Branch,
    output logic [CNT_W-1:0] Cnt_MemWait
);

    localparam int              WC_W    = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);
    localparam logic [WC_W-1:0] WC_INIT = WC_W'((MEM_LAT > 0) ? (MEM_LAT - 1) : 0);
    localparam logic            HAS_LAT = (MEM_LAT > 0);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t            r_state;
    logic [WC_W-1:0]   r_wcnt;
    logic [CNT_W-1:0]  r_cnt_lu;
    logic [CNT_W-1:0]  r_cnt_br;
    logic [CNT_W-1:0]  r_cnt_mw;

    logic w_mem_acc;
    logic w_lu;
    logic w_run_acc;
    logic w_mem_stall;
    logic w_br_act;
    logic w_lu_act;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    assign w_mem_acc = MEM_MemR | MEM_MemW;
    assign w_lu      = EX_MemR & (EX_Rdst != 5'd0) &
                       ((EX_Rdst == ID_Rs) | (ID_UseRt & (EX_Rdst == ID_Rt)));

    // Priority chain: a memory wait freezes everything, a branch beats a load-use bubble.
    assign w_run_acc   = (r_state == RUN) & w_mem_acc & HAS_LAT;
    assign w_mem_stall = w_run_acc | ((r_state == MEM_WAIT) & (r_wcnt != '0));
    assign w_br_act    = EX_BrTaken & ~w_mem_stall;
    assign w_lu_act    = w_lu & ~w_mem_stall & ~EX_BrTaken;

    assign PC_Stall     = rst & (w_mem_stall | w_lu_act);
    assign IF_ID_Stall  = rst & (w_mem_stall | w_lu_act);
    assign IF_ID_Flush  = rst & w_br_act;
    assign ID_EX_Stall  = rst & w_mem_stall;
    assign ID_EX_Flush  = rst & (w_br_act | w_lu_act);
    assign EX_MEM_Stall = rst & w_mem_stall;
    assign MEM_WB_Flush = rst & w_mem_stall;
    assign Mem_Busy     = rst & (r_state == MEM_WAIT);

    assign Cnt_LoadUse = r_cnt_lu;
    assign Cnt_Branch  = r_cnt_br;
    assign Cnt_MemWait = r_cnt_mw;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= RUN;
            r_wcnt   <= '0;
            r_cnt_lu <= '0;
            r_cnt_br <= '0;
            r_cnt_mw <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_run_acc) begin
                        r_state <= MEM_WAIT;
                        r_wcnt  <= WC_INIT;
                    end
                end
                MEM_WAIT: begin
                    // wcnt==0 is the release cycle: the access leaves MEM at this edge.
                    if (r_wcnt != '0) r_wcnt <= r_wcnt - WC_W'(1);
                    else              r_state <= RUN;
                end
                default: r_state <= RUN;
            endcase
            if (w_lu_act)    r_cnt_lu <= sat_inc(r_cnt_lu);
            if (w_br_act)    r_cnt_br <= sat_inc(r_cnt_br);
            if (w_mem_stall) r_cnt_mw <= sat_inc(r_cnt_mw);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: three instances (MEM_LAT=2/CNT_W=16,
// MEM_LAT=2/CNT_W=4, MEM_LAT=0/CNT_W=16) share one set of inputs.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] ID_Rs, ID_Rt, EX_Rdst;
    logic       ID_UseRt, EX_MemR, EX_BrTaken, MEM_MemR, MEM_MemW;

    logic a_pc, a_ifs, a_iff, a_ids, a_idf, a_exs, a_mwf, a_busy;
    logic b_pc, b_ifs, b_iff, b_ids, b_idf, b_exs, b_mwf, b_busy;
    logic z_pc, z_ifs, z_iff, z_ids, z_idf, z_exs, z_mwf, z_busy;
    logic [15:0] a_clu, a_cbr, a_cmw;
    logic [3:0]  b_clu, b_cbr, b_cmw;
    logic [15:0] z_clu, z_cbr, z_cmw;
    logic [7:0]  oa, ob, oz;

    int n_chk  = 0;
    int n_pass = 0;

    // Output vector layout: {PC_St, IFID_St, IFID_Fl, IDEX_St, IDEX_Fl, EXMEM_St, MEMWB_Fl, Busy}
    localparam logic [7:0] O_NONE = 8'h00;
    localparam logic [7:0] O_MEM  = 8'hD6;
    localparam logic [7:0] O_MEMB = 8'hD7;
    localparam logic [7:0] O_BR   = 8'h28;
    localparam logic [7:0] O_LU   = 8'hC8;

    assign oa = {a_pc, a_ifs, a_iff, a_ids, a_idf, a_exs, a_mwf, a_busy};
    assign ob = {b_pc, b_ifs, b_iff, b_ids, b_idf, b_exs, b_mwf, b_busy};
    assign oz = {z_pc, z_ifs, z_iff, z_ids, z_idf, z_exs, z_mwf, z_busy};

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MEM_LAT(2), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UseRt(ID_UseRt),
        .EX_Rdst(EX_Rdst), .EX_MemR(EX_MemR), .EX_BrTaken(EX_BrTaken),
        .MEM_MemR(MEM_MemR), .MEM_MemW(MEM_MemW),
        .PC_Stall(a_pc), .IF_ID_Stall(a_ifs), .IF_ID_Flush(a_iff), .ID_EX_Stall(a_ids),
        .ID_EX_Flush(a_idf), .EX_MEM_Stall(a_exs), .MEM_WB_Flush(a_mwf), .Mem_Busy(a_busy),
        .Cnt_LoadUse(a_clu), .Cnt_Branch(a_cbr), .Cnt_MemWait(a_cmw));

    pipe_hazard_ctrl #(.MEM_LAT(2), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UseRt(ID_UseRt),
        .EX_Rdst(EX_Rdst), .EX_MemR(EX_MemR), .EX_BrTaken(EX_BrTaken),
        .MEM_MemR(MEM_MemR), .MEM_MemW(MEM_MemW),
        .PC_Stall(b_pc), .IF_ID_Stall(b_ifs), .IF_ID_Flush(b_iff), .ID_EX_Stall(b_ids),
        .ID_EX_Flush(b_idf), .EX_MEM_Stall(b_exs), .MEM_WB_Flush(b_mwf), .Mem_Busy(b_busy),
        .Cnt_LoadUse(b_clu), .Cnt_Branch(b_cbr), .Cnt_MemWait(b_cmw));

    pipe_hazard_ctrl #(.MEM_LAT(0), .CNT_W(16)) dut_z (
        .clk(clk), .rst(rst), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UseRt(ID_UseRt),
        .EX_Rdst(EX_Rdst), .EX_MemR(EX_MemR), .EX_BrTaken(EX_BrTaken),
        .MEM_MemR(MEM_MemR), .MEM_MemW(MEM_MemW),
        .PC_Stall(z_pc), .IF_ID_Stall(z_ifs), .IF_ID_Flush(z_iff), .ID_EX_Stall(z_ids),
        .ID_EX_Flush(z_idf), .EX_MEM_Stall(z_exs), .MEM_WB_Flush(z_mwf), .Mem_Busy(z_busy),
        .Cnt_LoadUse(z_clu), .Cnt_Branch(z_cbr), .Cnt_MemWait(z_cmw));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        ID_Rs = 5'd0; ID_Rt = 5'd0; ID_UseRt = 1'b0; EX_Rdst = 5'd0;
        EX_MemR = 1'b0; EX_BrTaken = 1'b0; MEM_MemR = 1'b0; MEM_MemW = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        clear_in();
        // Reset forces outputs low even with every hazard source active
        #2;
        EX_BrTaken = 1'b1; MEM_MemR = 1'b1; EX_MemR = 1'b1; EX_Rdst = 5'd5; ID_Rs = 5'd5;
        #1;
        chk("rst_outs_a", 32'(oa), 32'(O_NONE));
        chk("rst_outs_z", 32'(oz), 32'(O_NONE));
        tick();
        chk("rst_cnt_a", 32'(a_clu) + 32'(a_cbr) + 32'(a_cmw), 32'd0);
        clear_in();
        rst = 1'b1;
        #1;
        chk("idle_outs", 32'(oa), 32'(O_NONE));

        // Reset mid-wait
        tick();
        MEM_MemR = 1'b1;
        #1;
        chk("mw_first", 32'(oa), 32'(O_MEM));
        chk("z_no_stall", 32'(oz), 32'(O_NONE));
        tick();
        MEM_MemR = 1'b0;
        #1;
        chk("mw_wait", 32'(oa), 32'(O_MEMB));
        chk("mw_cnt1", 32'(a_cmw), 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("rst_mid_outs", 32'(oa), 32'(O_NONE));
        chk("rst_mid_cnt", 32'(a_cmw), 32'd0);
        #1 rst = 1'b1;
        tick();
        chk("after_rst_run", 32'(oa), 32'(O_NONE));
        tick();
        chk("after_rst_run2", 32'(oa), 32'(O_NONE));

        // Load-use on Rs, $0 exemption, Rt gating by ID_UseRt
        EX_MemR = 1'b1; EX_Rdst = 5'd5; ID_Rs = 5'd5;
        #1;
        chk("lu_rs", 32'(oa), 32'(O_LU));
        tick();
        clear_in();
        #1;
        chk("lu_one_bubble", 32'(oa), 32'(O_NONE));
        chk("lu_cnt1", 32'(a_clu), 32'd1);
        EX_MemR = 1'b1; EX_Rdst = 5'd0; ID_Rs = 5'd0; ID_Rt = 5'd0; ID_UseRt = 1'b1;
        #1;
        chk("lu_r0", 32'(oa), 32'(O_NONE));
        EX_Rdst = 5'd5; ID_Rs = 5'd3; ID_Rt = 5'd5; ID_UseRt = 1'b0;
        #1;
        chk("lu_rt_unused", 32'(oa), 32'(O_NONE));
        ID_UseRt = 1'b1;
        #1;
        chk("lu_rt_used", 32'(oa), 32'(O_LU));
        tick();
        clear_in();
        #1;
        chk("lu_cnt2", 32'(a_clu), 32'd2);

        // Branch wins over load-use in the same cycle
        EX_BrTaken = 1'b1; EX_MemR = 1'b1; EX_Rdst = 5'd5; ID_Rs = 5'd5;
        #1;
        chk("br_over_lu", 32'(oa), 32'(O_BR));
        tick();
        clear_in();
        #1;
        chk("br_cnt1", 32'(a_cbr), 32'd1);
        chk("br_lu_unchanged", 32'(a_clu), 32'd2);

        // Memory wait: 2 stall cycles, release, back-to-back retrigger
        MEM_MemW = 1'b1;
        #1;
        chk("mem_c0", 32'(oa), 32'(O_MEM));
        chk("z_mem_c0", 32'(oz), 32'(O_NONE));
        tick();
        chk("mem_c1", 32'(oa), 32'(O_MEMB));
        tick();
        chk("mem_release", 32'(oa), 32'h01);
        chk("mem_cnt2", 32'(a_cmw), 32'd2);
        tick();
        chk("b2b_c0", 32'(oa), 32'(O_MEM));
        tick();
        chk("b2b_c1", 32'(oa), 32'(O_MEMB));
        tick();
        MEM_MemW = 1'b0;
        #1;
        chk("b2b_release", 32'(oa), 32'h01);
        tick();
        chk("mem_idle", 32'(oa), 32'(O_NONE));
        chk("mem_cnt4", 32'(a_cmw), 32'd4);

        // Masking: branch and load-use held through a memory wait
        MEM_MemR = 1'b1; EX_BrTaken = 1'b1; EX_MemR = 1'b1; EX_Rdst = 5'd5; ID_Rs = 5'd5;
        #1;
        chk("mask_c0", 32'(oa), 32'(O_MEM));
        chk("z_mask_br", 32'(oz), 32'(O_BR));
        tick();
        MEM_MemR = 1'b0;
        #1;
        chk("mask_c1", 32'(oa), 32'(O_MEMB));
        tick();
        chk("mask_release_br", 32'(oa), 32'h29);
        chk("mask_br_cnt", 32'(a_cbr), 32'd1);
        tick();
        clear_in();
        #1;
        chk("mask_br_cnt2", 32'(a_cbr), 32'd2);
        chk("mask_lu_cnt", 32'(a_clu), 32'd2);
        chk("mask_mw_cnt", 32'(a_cmw), 32'd6);

        // Saturation on the 4-bit instance after 20 more load-use cycles
        EX_MemR = 1'b1; EX_Rdst = 5'd7; ID_Rs = 5'd7;
        for (int i = 0; i < 20; i++) tick();
        clear_in();
        #1;
        chk("sat_lu_b", 32'(b_clu), 32'd15);
        chk("nosat_lu_a", 32'(a_clu), 32'd22);
        chk("b_mw_cnt", 32'(b_cmw), 32'd6);
        chk("b_br_cnt", 32'(b_cbr), 32'd2);

        // MEM_LAT=0: memory accesses never stall
        MEM_MemR = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("z_no_wait", 32'(oz), 32'(O_NONE));
            tick();
        end
        MEM_MemR = 1'b0;
        #1;
        chk("z_mw_cnt", 32'(z_cmw), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
